// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared definitions for the CPU memory-bus blocks. The arbiter uses them now,
//   and the cache controller will use the same state and port encodings.
//   Contents: default bus widths, the arbiter state enum, the grant-port
//   encoding, the streak counter width, and a saturating streak increment.
package cpu_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } bus_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } bus_port_e;

  // The streak counter stops at 15 so that STREAK_MAX can be any value from 1 to 15.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == '1) ? s : s + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Groups the fetch port, the load/store port, the stall outputs and the shared
//   memory-bus signals of mem_bus_arbiter.
//   Modport slave:  the arbiter's view. It takes requests and mem_ack/mem_rdata in,
//                   and drives acks, read data, stalls and the mem_* bus out.
//   Modport master: the opposite view, used by the core, the memory, or a bench.
interface mem_bus_arbiter_if
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int SEL_W = DATA_W / 8;

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  // load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [SEL_W-1:0]  d_sel;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  // pipeline stalls
  logic              stall_if;
  logic              stall_mem;
  // memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_sel, d_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_sel, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_sel, d_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_sel, mem_wdata
  );

endinterface

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr
//   Watchdog for a granted bus transfer. It is a down-counter that loads
//   TIMEOUT-1 when a grant starts and counts down while en_i is high.
//   expire_o is asserted during the TIMEOUT-th enabled cycle after the load.
//   Ports: clk, rst (async, active high), load_i, clear_i, en_i -> expire_o.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port memory bus between the instruction-fetch port and
//   the load/store port. Requests are served one at a time. Data has priority
//   over fetch, but a fetch that is waiting gets the bus after STREAK_MAX data
//   grants in a row. A transfer that gets no mem_ack ends after TIMEOUT grant
//   cycles and completes with err=1.
//   Ports: clk, rst (async, active high), bus (mem_bus_arbiter_if.slave).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | bus free; arbitrate between the requests now present
//   GRANT_I | fetch transfer on the bus; wait for mem_ack or timeout
//   GRANT_D | load/store transfer on the bus; wait for mem_ack or timeout
//   RESP    | one-cycle ack (with rdata/err) to the granted port
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  bus_state_e          state_q, state_d;
  bus_port_e           port_q, port_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;

  logic tmr_load, tmr_clear, tmr_en, tmr_expire;

  assign tmr_en = (state_q == GRANT_I) || (state_q == GRANT_D);

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .clear_i  (tmr_clear),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.d_req && (!bus.if_req || (streak_q < STREAK_LIM))) begin
          state_d     = GRANT_D;
          port_d      = PORT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_sel_d   = bus.d_sel;
          mem_wdata_d = bus.d_wdata;
          tmr_load    = 1'b1;
          // Count only the data grants that make a fetch wait.
          streak_d    = bus.if_req ? streak_inc(streak_q) : '0;
        end else if (bus.if_req) begin
          state_d     = GRANT_I;
          port_d      = PORT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_sel_d   = '1;
          mem_wdata_d = '0;
          tmr_load    = 1'b1;
          streak_d    = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ack || tmr_expire) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          tmr_clear = 1'b1;
          if_ack_d  = (port_q == PORT_IF);
          d_ack_d   = (port_q == PORT_D);
          // mem_ack takes priority when it arrives in the last timer cycle.
          err_d     = !bus.mem_ack;
          rdata_d   = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= PORT_IF;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  // One rdata/err register serves both ports. Each port sees the value only while its own ack is high.
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_ack_q ? rdata_q : '0;
  assign bus.if_err    = if_ack_q & err_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_ack_q ? rdata_q : '0;
  assign bus.d_err     = d_ack_q & err_q;

  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.d_req & ~d_ack_q;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STREAK_MAX(4), .TIMEOUT(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // memory responder controls
  int          ack_delay = 1;   // 0 means the memory never acks
  logic [31:0] rd_val    = 32'h0;
  logic        late_ack  = 1'b0;
  int          req_cnt   = 0;
  int          if_acks   = 0;
  int          d_acks    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // d_port=1 waits for d_ack, d_port=0 waits for if_ack; cyc counts edges
  task automatic wait_ack(input bit d_port, input string tag, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(d_port ? bus.d_ack : bus.if_ack) && cyc < 300);
    chk(tag, d_port ? bus.d_ack : bus.if_ack, 1'b1);
  endtask

  // Memory model and ack counter run on the falling edge, away from DUT edges.
  always @(negedge clk) begin
    if (bus.if_ack) if_acks++;
    if (bus.d_ack)  d_acks++;
    if (bus.mem_req) begin
      req_cnt++;
      bus.mem_ack   = (ack_delay != 0) && (req_cnt == ack_delay);
      bus.mem_rdata = bus.mem_ack ? rd_val : 32'h0BAD_0BAD;
    end else begin
      req_cnt       = 0;
      bus.mem_ack   = late_ack;
      bus.mem_rdata = late_ack ? 32'hFFFF_FFFF : 32'h0BAD_0BAD;
    end
  end

  int cyc;
  int cnt_snap, ifcnt_snap;
  int order[$];
  int exp_ord[7];
  int dn;
  bit stall_ok;

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_sel = 0; bus.d_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;

    // 1: reset for 10 cycles, then idle with no requests
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_mem_req", bus.mem_req, 0);
    end
    chk("idle_mem_we", bus.mem_we, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_mem_sel", bus.mem_sel, 0);
    chk("idle_mem_wdata", bus.mem_wdata, 0);
    chk("idle_if_ack", bus.if_ack, 0);
    chk("idle_if_rdata", bus.if_rdata, 0);
    chk("idle_if_err", bus.if_err, 0);
    chk("idle_d_ack", bus.d_ack, 0);
    chk("idle_d_rdata", bus.d_rdata, 0);
    chk("idle_d_err", bus.d_err, 0);
    chk("idle_stall_if", bus.stall_if, 0);
    chk("idle_stall_mem", bus.stall_mem, 0);

    // 2: fetch from 0x10, memory acks 2 cycles after mem_req
    rd_val = 32'h2001_0005; ack_delay = 2;
    bus.if_addr = 32'h10; bus.if_req = 1;
    #1 chk("t2_stall_if_start", bus.stall_if, 1);
    cyc = 0; stall_ok = 1;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        chk("t2_mem_req", bus.mem_req, 1);
        chk("t2_mem_addr", bus.mem_addr, 32'h10);
        chk("t2_mem_we", bus.mem_we, 0);
      end
      if (!bus.if_ack && !bus.stall_if) stall_ok = 0;
    end while (!bus.if_ack && cyc < 100);
    chk("t2_if_ack", bus.if_ack, 1);
    chk("t2_latency", cyc, 3);
    chk("t2_stall_held", stall_ok, 1);
    chk("t2_if_rdata", bus.if_rdata, 32'h2001_0005);
    chk("t2_if_err", bus.if_err, 0);
    chk("t2_stall_if_ack", bus.stall_if, 0);
    chk("t2_d_ack", bus.d_ack, 0);
    bus.if_req = 0;
    step();
    chk("t2_ack_pulse", bus.if_ack, 0);
    chk("t2_rdata_clr", bus.if_rdata, 0);

    // 3: fetch and load raised together, data first, fetch after one idle cycle
    rd_val = 32'h1234_5678; ack_delay = 1;
    bus.if_addr = 32'h10; bus.if_req = 1;
    bus.d_addr = 32'h100; bus.d_we = 0; bus.d_sel = 4'hF; bus.d_req = 1;
    wait_ack(1'b1, "t3_d_ack", cyc);
    chk("t3_d_latency", cyc, 2);
    chk("t3_d_rdata", bus.d_rdata, 32'h1234_5678);
    chk("t3_if_not_yet", bus.if_ack, 0);
    chk("t3_stall_if", bus.stall_if, 1);
    bus.d_req = 0;
    step();
    chk("t3_idle_gap", bus.mem_req, 0);
    step();
    chk("t3_fetch_req", bus.mem_req, 1);
    chk("t3_fetch_addr", bus.mem_addr, 32'h10);
    wait_ack(1'b0, "t3_if_ack", cyc);
    chk("t3_if_rdata", bus.if_rdata, 32'h1234_5678);
    bus.if_req = 0;
    step();

    // 4: six back-to-back loads with a fetch pending -> D,D,D,D,I,D,D
    rd_val = 32'h0BEE_F000; ack_delay = 1;
    bus.if_addr = 32'h40; bus.if_req = 1;
    bus.d_addr = 32'h300; bus.d_we = 0; bus.d_req = 1;
    dn = 0; cyc = 0;
    order.delete();
    while (!((dn >= 6) && !bus.if_req) && cyc < 200) begin
      step();
      cyc++;
      if (bus.d_ack) begin
        order.push_back(1);
        dn++;
        if (dn == 6) bus.d_req = 0;
      end
      if (bus.if_ack) begin
        order.push_back(0);
        bus.if_req = 0;
      end
    end
    exp_ord = '{1, 1, 1, 1, 0, 1, 1};
    chk("t4_grants", order.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < order.size()) chk($sformatf("t4_order%0d", i), order[i], exp_ord[i]);
    end
    bus.if_req = 0; bus.d_req = 0;
    step();

    // 5: store 0xDEADBEEF, sel 0011, to 0x200
    rd_val = 32'h5555_5555; ack_delay = 3;
    bus.d_we = 1; bus.d_addr = 32'h200; bus.d_sel = 4'b0011; bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_req = 1;
    step();
    chk("t5_mem_req", bus.mem_req, 1);
    chk("t5_mem_we", bus.mem_we, 1);
    chk("t5_mem_addr", bus.mem_addr, 32'h200);
    chk("t5_mem_sel", bus.mem_sel, 4'b0011);
    chk("t5_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    wait_ack(1'b1, "t5_d_ack", cyc);
    chk("t5_latency", cyc, 3);
    chk("t5_d_rdata", bus.d_rdata, 0);
    chk("t5_d_err", bus.d_err, 0);
    bus.d_req = 0; bus.d_we = 0;
    step();

    // 6: no mem_ack -> timeout after 64 grant cycles; a late ack is ignored
    rd_val = 32'h7777_7777; ack_delay = 0;
    bus.d_addr = 32'h400; bus.d_sel = 4'hF; bus.d_req = 1;
    wait_ack(1'b1, "t6_d_ack", cyc);
    chk("t6_latency", cyc, 65);
    chk("t6_d_err", bus.d_err, 1);
    chk("t6_d_rdata", bus.d_rdata, 0);
    chk("t6_mem_req", bus.mem_req, 0);
    late_ack = 1;
    bus.d_req = 0;
    step();
    cnt_snap = d_acks; ifcnt_snap = if_acks;
    repeat (3) step();
    late_ack = 0;
    step();
    chk("t6_no_extra_d_ack", d_acks, cnt_snap);
    chk("t6_no_if_ack", if_acks, ifcnt_snap);
    chk("t6_mem_req_idle", bus.mem_req, 0);

    // 7: reset in the middle of a grant, then the same request again
    rd_val = 32'h0C0F_FEE0; ack_delay = 5;
    bus.d_addr = 32'h500; bus.d_we = 0; bus.d_req = 1;
    step();
    step();
    chk("t7_in_grant", bus.mem_req, 1);
    cnt_snap = d_acks;
    rst = 1;
    #1;
    chk("t7_async_drop", bus.mem_req, 0);
    chk("t7_no_ack", bus.d_ack, 0);
    chk("t7_stall_mem", bus.stall_mem, 1);
    repeat (2) step();
    rst = 0;
    chk("t7_no_ack_cnt", d_acks, cnt_snap);
    wait_ack(1'b1, "t7_d_ack", cyc);
    chk("t7_latency", cyc, 6);
    chk("t7_d_rdata", bus.d_rdata, 32'h0C0F_FEE0);
    chk("t7_d_err", bus.d_err, 0);
    bus.d_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
